// File: rtl/tt_um_modcounter_shivam.sv
// Modulo-N up/down timer/counter tile with prescaler, one-shot mode, compare output
// and sticky terminal flag. All state is synchronous to clk apart from the async reset.
module tt_um_modcounter_shivam #(
    parameter int WIDTH  = 8,
    parameter int MODULO = 2 ** WIDTH,
    parameter int PW     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up,
    input  logic             mode,
    input  logic [PW-1:0]    presc,
    input  logic [WIDTH-1:0] cmp_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             match,
    output logic             wrapped,
    output logic             done
);

    if (MODULO < 2 || MODULO > (2 ** WIDTH)) begin : gBadModulo
        $error("tt_um_modcounter_shivam: MODULO must lie in 2 .. 2**WIDTH");
    end

    localparam logic [WIDTH-1:0] TERM_MAX = WIDTH'(MODULO - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [PW-1:0]    pcnt_q, pcnt_d;
    logic             tc_q, tc_d;
    logic             wrapped_q, wrapped_d;
    logic             done_q, done_d;
    logic             tick;
    logic             atTerminal;

    // A pcnt above a freshly lowered presc simply runs on through its natural wrap.
    assign tick       = en && (pcnt_q == presc);
    assign atTerminal = up ? (count_q == TERM_MAX) : (count_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            pcnt_q    <= '0;
            tc_q      <= 1'b0;
            wrapped_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            pcnt_q    <= pcnt_d;
            tc_q      <= tc_d;
            wrapped_q <= wrapped_d;
            done_q    <= done_d;
        end
    end

    // Edge priority is clear, then load, then prescaler tick.
    always_comb begin
        count_d   = count_q;
        pcnt_d    = pcnt_q;
        tc_d      = 1'b0;
        wrapped_d = wrapped_q;
        done_d    = done_q;
        if (clr) begin
            count_d   = '0;
            pcnt_d    = '0;
            wrapped_d = 1'b0;
            done_d    = 1'b0;
        end else if (load) begin
            count_d = (load_val > TERM_MAX) ? TERM_MAX : load_val;
            pcnt_d  = '0;
            done_d  = 1'b0;
        end else begin
            if (tick) begin
                pcnt_d = '0;
            end else if (en) begin
                pcnt_d = pcnt_q + PW'(1);
            end
            if (tick && !done_q) begin
                if (atTerminal) begin
                    tc_d      = 1'b1;
                    wrapped_d = 1'b1;
                    if (mode) begin
                        done_d = 1'b1;
                    end else begin
                        count_d = up ? '0 : TERM_MAX;
                    end
                end else begin
                    count_d = up ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
                end
            end
        end
    end

    assign count   = count_q;
    assign tc      = tc_q;
    assign wrapped = wrapped_q;
    assign done    = done_q;
    assign match   = (cmp_val <= TERM_MAX) && (count_q == cmp_val);

endmodule

// File: tb/tb_tt_um_modcounter_shivam.sv
// Directed-vector bench for the modulo-10 configuration of the counter tile;
// expected values are worked out by hand from the counter's rules.
module tb_tt_um_modcounter_shivam;

    logic       clk;
    logic       rst;
    logic       en;
    logic       clr;
    logic       load;
    logic [7:0] loadVal;
    logic       up;
    logic       mode;
    logic [3:0] presc;
    logic [7:0] cmpVal;
    logic [7:0] count;
    logic       tc;
    logic       match;
    logic       wrapped;
    logic       done;

    int checkCount;
    int errorCount;

    tt_um_modcounter_shivam #(
        .WIDTH (8),
        .MODULO(10),
        .PW    (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .clr     (clr),
        .load    (load),
        .load_val(loadVal),
        .up      (up),
        .mode    (mode),
        .presc   (presc),
        .cmp_val (cmpVal),
        .count   (count),
        .tc      (tc),
        .match   (match),
        .wrapped (wrapped),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advances n rising edges; inputs are changed and outputs sampled on falling edges.
    task automatic applyStimulus(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        rst     = 1'b1;
        en      = 1'b0;
        clr     = 1'b0;
        load    = 1'b0;
        loadVal = 8'd0;
        up      = 1'b1;
        mode    = 1'b0;
        presc   = 4'd0;
        cmpVal  = 8'd0;

        applyStimulus(2);
        checkOutput("reset count", count, 0);
        checkOutput("reset tc", tc, 0);
        checkOutput("reset wrapped", wrapped, 0);
        checkOutput("reset done", done, 0);

        // Free-run wrap at presc=0.
        $display("[TB] free-run wrap");
        rst = 1'b0;
        en  = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            applyStimulus(1);
            checkOutput("run count", count, i % 10);
            checkOutput("run tc", tc, (i == 10) ? 1 : 0);
            checkOutput("run wrapped", wrapped, (i >= 10) ? 1 : 0);
        end

        // Prescaler divide-by-3, then enable gating.
        $display("[TB] prescaler");
        clr = 1'b1;
        applyStimulus(1);
        checkOutput("clr count", count, 0);
        checkOutput("clr wrapped", wrapped, 0);
        clr   = 1'b0;
        presc = 4'd2;
        for (int i = 1; i <= 9; i++) begin
            applyStimulus(1);
            checkOutput("presc count", count, i / 3);
        end
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1);
            checkOutput("en0 hold", count, 3);
        end

        // Down count in one-shot mode.
        $display("[TB] down one-shot");
        en      = 1'b1;
        presc   = 4'd0;
        up      = 1'b0;
        mode    = 1'b1;
        load    = 1'b1;
        loadVal = 8'd2;
        applyStimulus(1);
        checkOutput("os load count", count, 2);
        load = 1'b0;
        applyStimulus(1);
        checkOutput("os count1", count, 1);
        checkOutput("os tc1", tc, 0);
        applyStimulus(1);
        checkOutput("os count0", count, 0);
        checkOutput("os tc0", tc, 0);
        checkOutput("os done0", done, 0);
        applyStimulus(1);
        checkOutput("os term count", count, 0);
        checkOutput("os term tc", tc, 1);
        checkOutput("os term done", done, 1);
        checkOutput("os term wrapped", wrapped, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1);
            checkOutput("os held count", count, 0);
            checkOutput("os held tc", tc, 0);
            checkOutput("os held done", done, 1);
        end
        load    = 1'b1;
        loadVal = 8'd5;
        applyStimulus(1);
        checkOutput("os reload count", count, 5);
        checkOutput("os reload done", done, 0);
        checkOutput("os reload wrapped", wrapped, 1);

        // Priority, clamping and load-over-tick.
        $display("[TB] priority and clamp");
        clr     = 1'b1;
        loadVal = 8'd7;
        applyStimulus(1);
        checkOutput("clr>load count", count, 0);
        checkOutput("clr>load wrapped", wrapped, 0);
        clr     = 1'b0;
        loadVal = 8'd200;
        applyStimulus(1);
        checkOutput("clamp count", count, 9);
        mode    = 1'b0;
        up      = 1'b1;
        loadVal = 8'd4;
        applyStimulus(1);
        checkOutput("load>tick count", count, 4);
        load = 1'b0;
        applyStimulus(1);
        checkOutput("after load count", count, 5);
        load    = 1'b1;
        loadVal = 8'd9;
        applyStimulus(1);
        load = 1'b0;
        up   = 1'b0;
        applyStimulus(1);
        checkOutput("dir change count", count, 8);
        checkOutput("dir change tc", tc, 0);

        // Compare output.
        $display("[TB] compare");
        clr    = 1'b1;
        up     = 1'b1;
        cmpVal = 8'd7;
        applyStimulus(1);
        clr = 1'b0;
        checkOutput("match at 0", match, 0);
        for (int i = 1; i <= 9; i++) begin
            applyStimulus(1);
            checkOutput("match count", count, i);
            checkOutput("match flag", match, (i == 7) ? 1 : 0);
        end
        cmpVal = 8'd12;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1);
            checkOutput("match oor", match, 0);
        end
        checkOutput("oor end count", count, 9);
        checkOutput("oor wrapped", wrapped, 1);

        // Asynchronous reset between edges.
        $display("[TB] async reset");
        en      = 1'b0;
        load    = 1'b1;
        loadVal = 8'd6;
        applyStimulus(1);
        load = 1'b0;
        checkOutput("pre-rst count", count, 6);
        #2 rst = 1'b1;
        #1;
        checkOutput("async rst count", count, 0);
        checkOutput("async rst wrapped", wrapped, 0);
        checkOutput("async rst tc", tc, 0);
        checkOutput("async rst done", done, 0);
        applyStimulus(1);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
